// File: rtl/adxl362_pkg.sv
// ADXL362 responder shared constants, register map and FSM encoding.
// Optional DATA_READY tracking is enabled with ADXL_RESP_DRDY_EN.
package adxl362_pkg;

  localparam logic [7:0] CMD_WR = 8'h0A;
  localparam logic [7:0] CMD_RD = 8'h0B;

  localparam logic [7:0] A_DEVID      = 8'h00;
  localparam logic [7:0] A_DEVID_MST  = 8'h01;
  localparam logic [7:0] A_PARTID     = 8'h02;
  localparam logic [7:0] A_REVID      = 8'h03;
  localparam logic [7:0] A_XDATA      = 8'h08;
  localparam logic [7:0] A_YDATA      = 8'h09;
  localparam logic [7:0] A_ZDATA      = 8'h0A;
  localparam logic [7:0] A_STATUS     = 8'h0B;
  localparam logic [7:0] A_XDATA_L    = 8'h0E;
  localparam logic [7:0] A_XDATA_H    = 8'h0F;
  localparam logic [7:0] A_YDATA_L    = 8'h10;
  localparam logic [7:0] A_YDATA_H    = 8'h11;
  localparam logic [7:0] A_ZDATA_L    = 8'h12;
  localparam logic [7:0] A_ZDATA_H    = 8'h13;
  localparam logic [7:0] A_SOFT_RESET = 8'h1F;
  localparam logic [7:0] A_FILTER_CTL = 8'h2C;
  localparam logic [7:0] A_POWER_CTL  = 8'h2D;

  localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;
  localparam logic [7:0] REVID_VAL      = 8'h01;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD,
    ST_WR,
    ST_IGNORE
  } state_e;

  // Upper data byte: sign-extended bits [11:8].
  function automatic logic [7:0] hi_ext(
    input logic [11:0] v
  );
    return {{4{v[11]}}, v[11:8]};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes sclk/cs_n/mosi into clk and flags their edges.
// No optional features.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  localparam int N = SYNC_STAGES;

  logic [N-1:0] sclk_sync_q, sclk_sync_d;
  logic [N-1:0] cs_sync_q, cs_sync_d;
  logic [N-1:0] mosi_sync_q, mosi_sync_d;
  logic         sclk_prev_q, sclk_prev_d;
  logic         cs_prev_q, cs_prev_d;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[N-2:0], sclk};
    cs_sync_d   = {cs_sync_q[N-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[N-2:0], mosi};
    sclk_prev_d = sclk_sync_q[N-1];
    cs_prev_d   = cs_sync_q[N-1];
  end

  // cs_n idles high so reset never fakes a select edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk_rise = sclk_sync_q[N-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[N-1] & sclk_prev_q;
  assign cs_fall   = ~cs_sync_q[N-1] & cs_prev_q;
  assign cs_rise   = cs_sync_q[N-1] & ~cs_prev_q;
  assign mosi_s    = mosi_sync_q[N-1];

endmodule

// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface emulator on SPI mode 0.
// Define ADXL_RESP_DRDY_EN for live STATUS DATA_READY tracking.
module adxl362_spi_responder
  import adxl362_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] x_sample,
  input  logic [11:0] y_sample,
  input  logic [11:0] z_sample,
  input  logic        sample_stb,
  output logic        measuring,
  output logic        cmd_err
);

  logic sclk_rise, sclk_fall;
  logic cs_fall, cs_rise, mosi_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        miso_q, miso_d;
  logic        cmd_err_q, cmd_err_d;
  logic [7:0]  pwr_q, pwr_d;
  logic [7:0]  flt_q, flt_d;
  logic [11:0] stg_x_q, stg_x_d;
  logic [11:0] stg_y_q, stg_y_d;
  logic [11:0] stg_z_q, stg_z_d;
  logic [11:0] snp_x_q, snp_x_d;
  logic [11:0] snp_y_q, snp_y_d;
  logic [11:0] snp_z_q, snp_z_d;
`ifdef ADXL_RESP_DRDY_EN
  logic        drdy_q, drdy_d;
  logic        hit_q, hit_d;
`endif

  logic [7:0] rx_byte;
  logic [7:0] addr_inc;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] status;

  assign measuring = (pwr_q[1:0] == 2'b10);
  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign addr_inc  = addr_q + 8'd1;
  assign rd_addr   = (state_q == ST_ADDR) ? rx_byte : addr_inc;

`ifdef ADXL_RESP_DRDY_EN
  assign status = {1'b0, measuring, 5'b0, drdy_q};
`else
  assign status = {1'b0, measuring, 5'b0, 1'b1};
`endif

  always_comb begin
    rd_data = '0;
    unique case (rd_addr)
      A_DEVID:      rd_data = DEVID_AD;
      A_DEVID_MST:  rd_data = DEVID_MST_VAL;
      A_PARTID:     rd_data = PARTID;
      A_REVID:      rd_data = REVID_VAL;
      A_XDATA:      rd_data = snp_x_q[11:4];
      A_YDATA:      rd_data = snp_y_q[11:4];
      A_ZDATA:      rd_data = snp_z_q[11:4];
      A_STATUS:     rd_data = status;
      A_XDATA_L:    rd_data = snp_x_q[7:0];
      A_XDATA_H:    rd_data = hi_ext(snp_x_q);
      A_YDATA_L:    rd_data = snp_y_q[7:0];
      A_YDATA_H:    rd_data = hi_ext(snp_y_q);
      A_ZDATA_L:    rd_data = snp_z_q[7:0];
      A_ZDATA_H:    rd_data = hi_ext(snp_z_q);
      A_FILTER_CTL: rd_data = flt_q;
      A_POWER_CTL:  rd_data = pwr_q;
      default:      rd_data = '0;
    endcase
    // Sample registers read as zero unless measuring.
    if (!measuring &&
        (rd_addr inside {[A_XDATA:A_ZDATA],
                         [A_XDATA_L:A_ZDATA_H]}))
      rd_data = '0;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    miso_d    = miso_q;
    cmd_err_d = 1'b0;
    pwr_d     = pwr_q;
    flt_d     = flt_q;
    stg_x_d   = stg_x_q;
    stg_y_d   = stg_y_q;
    stg_z_d   = stg_z_q;
    snp_x_d   = snp_x_q;
    snp_y_d   = snp_y_q;
    snp_z_d   = snp_z_q;
`ifdef ADXL_RESP_DRDY_EN
    drdy_d    = drdy_q;
    hit_d     = hit_q;
`endif

    if (sample_stb) begin
      stg_x_d = x_sample;
      stg_y_d = y_sample;
      stg_z_d = z_sample;
`ifdef ADXL_RESP_DRDY_EN
      if (measuring) drdy_d = 1'b1;
`endif
    end

    if (cs_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      snp_x_d   = stg_x_q;
      snp_y_d   = stg_y_q;
      snp_z_d   = stg_z_q;
`ifdef ADXL_RESP_DRDY_EN
      hit_d     = 1'b0;
`endif
    end else if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
`ifdef ADXL_RESP_DRDY_EN
      if (hit_q) drdy_d = 1'b0;
`endif
    end else begin
      if (sclk_rise && state_q != ST_IDLE &&
          state_q != ST_IGNORE) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            ST_CMD: begin
              if (rx_byte == CMD_RD) begin
                state_d = ST_ADDR;
                wr_d    = 1'b0;
              end else if (rx_byte == CMD_WR) begin
                state_d = ST_ADDR;
                wr_d    = 1'b1;
              end else begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
                miso_d    = 1'b0;
              end
            end
            ST_ADDR: begin
              addr_d  = rx_byte;
              state_d = wr_q ? ST_WR : ST_RD;
              if (!wr_q) tx_d = rd_data;
            end
            ST_RD: begin
              addr_d = addr_inc;
              tx_d   = rd_data;
`ifdef ADXL_RESP_DRDY_EN
              if (addr_q == A_XDATA_L || addr_q == A_XDATA)
                hit_d = 1'b1;
`endif
            end
            ST_WR: begin
              addr_d = addr_inc;
              if (addr_q == A_FILTER_CTL) begin
                flt_d = rx_byte;
              end else if (addr_q == A_POWER_CTL) begin
                pwr_d = rx_byte;
              end else if (addr_q == A_SOFT_RESET &&
                           rx_byte == SOFT_RESET_KEY) begin
                pwr_d = POWER_CTL_RST;
                flt_d = FILTER_CTL_RST;
              end
            end
            default: ;
          endcase
        end
      end
      if (sclk_fall && state_q == ST_RD) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      pwr_q     <= POWER_CTL_RST;
      flt_q     <= FILTER_CTL_RST;
      stg_x_q   <= '0;
      stg_y_q   <= '0;
      stg_z_q   <= '0;
      snp_x_q   <= '0;
      snp_y_q   <= '0;
      snp_z_q   <= '0;
`ifdef ADXL_RESP_DRDY_EN
      drdy_q    <= 1'b0;
      hit_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      miso_q    <= miso_d;
      cmd_err_q <= cmd_err_d;
      pwr_q     <= pwr_d;
      flt_q     <= flt_d;
      stg_x_q   <= stg_x_d;
      stg_y_q   <= stg_y_d;
      stg_z_q   <= stg_z_d;
      snp_x_q   <= snp_x_d;
      snp_y_q   <= snp_y_d;
      snp_z_q   <= snp_z_d;
`ifdef ADXL_RESP_DRDY_EN
      drdy_q    <= drdy_d;
      hit_q     <= hit_d;
`endif
    end
  end

  assign miso    = miso_q;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Bench for adxl362_spi_responder: SPI bursts checked against a register model.
// Model follows ADXL_RESP_DRDY_EN when it is defined.
module tb_adxl362_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs_n, mosi, miso;
  logic [11:0] x_sample, y_sample, z_sample;
  logic        sample_stb;
  logic        measuring, cmd_err;

  int n_chk  = 0;
  int n_fail = 0;
  int err_pulses = 0;

  logic [7:0]  m_pwr, m_flt;
  logic [11:0] m_stg [3];
  logic [11:0] m_snp [3];
  bit          m_drdy, m_hit;

  always #5 clk = ~clk;

  adxl362_spi_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .x_sample  (x_sample),
    .y_sample  (y_sample),
    .z_sample  (z_sample),
    .sample_stb(sample_stb),
    .measuring (measuring),
    .cmd_err   (cmd_err)
  );

  always @(negedge clk)
    if (cmd_err === 1'b1) err_pulses++;

  function automatic bit m_meas();
    return m_pwr[1:0] == 2'b10;
  endfunction

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    int idx, s;
    logic [11:0] v;
    if (a >= 8'h08 && a <= 8'h0A) begin
      v = m_snp[a - 8'h08];
      if (!m_meas()) return 8'h00;
      s = v[11] ? int'(v) - 4096 : int'(v);
      return 8'((s >>> 4) & 255);
    end
    if (a >= 8'h0E && a <= 8'h13) begin
      idx = (int'(a) - 14) / 2;
      v = m_snp[idx];
      if (!m_meas()) return 8'h00;
      s = v[11] ? int'(v) - 4096 : int'(v);
      if ((int'(a) - 14) % 2 == 0) return 8'(s & 255);
      return 8'((s >>> 8) & 255);
    end
    case (a)
      8'h00: return 8'hAD;
      8'h01: return 8'h1D;
      8'h02: return 8'hF2;
      8'h03: return 8'h01;
`ifdef ADXL_RESP_DRDY_EN
      8'h0B: return {1'b0, m_meas(), 5'b0, m_drdy};
`else
      8'h0B: return {1'b0, m_meas(), 5'b0, 1'b1};
`endif
      8'h2C: return m_flt;
      8'h2D: return m_pwr;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    m_pwr = 8'h00;
    m_flt = 8'h13;
    for (int i = 0; i < 3; i++) begin
      m_stg[i] = '0;
      m_snp[i] = '0;
    end
    m_drdy = 0;
    m_hit  = 0;
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    half();
    r = miso;
    sclk = 1'b1;
    half();
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx,
                          output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    for (int i = 0; i < 3; i++) m_snp[i] = m_stg[i];
    m_hit = 0;
    half();
  endtask

  task automatic cs_hi();
    half();
    cs_n = 1'b1;
    if (m_hit) m_drdy = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic strobe(input logic [11:0] x,
                        input logic [11:0] y,
                        input logic [11:0] z);
    @(negedge clk);
    x_sample = x;
    y_sample = y;
    z_sample = z;
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    m_stg[0] = x;
    m_stg[1] = y;
    m_stg[2] = z;
    if (m_meas()) m_drdy = 1;
  endtask

  task automatic read_bytes(input logic [7:0] start, input int n,
                            input string name);
    logic [7:0] rx, exp, a;
    for (int k = 0; k < n; k++) begin
      a = start + 8'(k);
      exp = m_reg(a);
      spi_byte(8'h00, rx);
      if (a == 8'h0E || a == 8'h08) m_hit = 1;
      n_chk++;
      if (rx !== exp) begin
        n_fail++;
        $display("FAIL %s addr=%02h got=%02h exp=%02h",
                 name, a, rx, exp);
      end
    end
  endtask

  task automatic do_read(input logic [7:0] start, input int n,
                         input string name);
    logic [7:0] rx;
    cs_lo();
    spi_byte(8'h0B, rx);
    spi_byte(start, rx);
    n_chk++;
    if (rx !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_hdr miso=%02h exp=00", name, rx);
    end
    read_bytes(start, n, name);
    cs_hi();
  endtask

  task automatic do_write(input logic [7:0] addr,
                          input logic [7:0] d0,
                          input logic [7:0] d1, input int n);
    logic [7:0] rx, a, d;
    cs_lo();
    spi_byte(8'h0A, rx);
    spi_byte(addr, rx);
    for (int k = 0; k < n; k++) begin
      a = addr + 8'(k);
      d = (k == 0) ? d0 : d1;
      spi_byte(d, rx);
      if (a == 8'h2C) m_flt = d;
      else if (a == 8'h2D) m_pwr = d;
      else if (a == 8'h1F && d == 8'h52) begin
        m_pwr = 8'h00;
        m_flt = 8'h13;
      end
    end
    cs_hi();
  endtask

  task automatic chk_meas(input string name);
    n_chk++;
    if (measuring !== m_meas()) begin
      n_fail++;
      $display("FAIL %s measuring=%0b exp=%0b",
               name, measuring, m_meas());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    sample_stb = 1'b0;
    x_sample = '0;
    y_sample = '0;
    z_sample = '0;
    model_reset();
    repeat (3) @(negedge clk);
    x_sample = 12'h7FF;
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    n_chk++;
    if ({miso, measuring, cmd_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset outs=%03b exp=000",
               {miso, measuring, cmd_err});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_read(8'h2C, 2, "reset_ctl");
    do_write(8'h2D, 8'h02, 8'h00, 1);
    do_read(8'h08, 1, "reset_stb_ign");
  endtask

  task automatic test_id_read();
    do_read(8'h00, 4, "id");
  endtask

  task automatic test_write_power();
    do_write(8'h2D, 8'h02, 8'h00, 1);
    do_read(8'h2D, 1, "pwr_rb");
    chk_meas("pwr_meas");
  endtask

  task automatic test_samples();
    strobe(12'h9A5, 12'h123, 12'($urandom));
    do_read(8'h0E, 4, "xy_meas");
    do_read(8'h08, 6, "xyz_hi_status");
    do_write(8'h2D, 8'h00, 8'h00, 1);
    chk_meas("meas_off");
    do_read(8'h0E, 4, "xy_off");
    do_read(8'h0B, 1, "status_off");
  endtask

  task automatic test_mid_burst_stb();
    logic [7:0] rx;
    do_write(8'h2D, 8'h02, 8'h00, 1);
    strobe(12'h9A5, 12'h123, 12'h800);
    cs_lo();
    spi_byte(8'h0B, rx);
    spi_byte(8'h0E, rx);
    read_bytes(8'h0E, 1, "mid_b0");
    strobe(12'($urandom), 12'($urandom), 12'h456);
    read_bytes(8'h0F, 3, "mid_rest");
    cs_hi();
    do_read(8'h0E, 6, "mid_next");
  endtask

  task automatic test_wrap();
    do_read(8'hFF, 2, "wrap");
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    int p0;
    p0 = err_pulses;
    cs_lo();
    spi_byte(8'h0D, rx);
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'hFF, rx);
      n_chk++;
      if (rx !== 8'h00) begin
        n_fail++;
        $display("FAIL bad_cmd_miso got=%02h exp=00", rx);
      end
    end
    cs_hi();
    n_chk++;
    if (err_pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL cmd_err_pulse cycles=%0d exp=1",
               err_pulses - p0);
    end
  endtask

  task automatic test_soft_reset();
    do_write(8'h2C, 8'h47, 8'h00, 1);
    do_write(8'h2D, 8'h02, 8'h00, 1);
    do_write(8'h1F, 8'h51, 8'h00, 1);
    do_read(8'h2C, 2, "soft_wrong_key");
    do_write(8'h1F, 8'h52, 8'h00, 1);
    do_read(8'h2C, 2, "soft_reset");
    chk_meas("soft_meas");
  endtask

  task automatic test_partial_write();
    logic [7:0] rx;
    logic b;
    cs_lo();
    spi_byte(8'h0A, rx);
    spi_byte(8'h2C, rx);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
    cs_hi();
    n_chk++;
    if (miso !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_miso got=%0b exp=0", miso);
    end
    do_read(8'h2C, 1, "partial_wr");
  endtask

  task automatic test_random();
    int op;
    logic [7:0] a, d;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: strobe(12'($urandom), 12'($urandom),
                  12'($urandom));
        1: begin
          case ($urandom_range(0, 3))
            0: a = 8'h2C;
            1: a = 8'h2D;
            2: a = 8'h1F;
            default: a = 8'($urandom);
          endcase
          d = ($urandom_range(0, 1) == 1) ? 8'h02
                                          : 8'($urandom);
          if (a == 8'h1F && $urandom_range(0, 1) == 1)
            d = 8'h52;
          do_write(a, d, 8'($urandom),
                   $urandom_range(1, 2));
          chk_meas("rnd_meas");
        end
        2: do_read(8'($urandom), $urandom_range(1, 4),
                   "rnd_read");
        default: do_read(($urandom_range(0, 1) == 1)
                         ? 8'h08 : 8'h0E,
                         $urandom_range(4, 6), "rnd_data");
      endcase
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    cs_lo();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    mosi = 1'b0;
    half();
    n_chk++;
    if (miso !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_miso got=%0b exp=1", miso);
    end
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (miso !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_miso got=%0b exp=0", miso);
    end
    sclk = 1'b0;
    cs_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_meas("rst_mid_meas");
    do_read(8'h2C, 2, "rst_mid_after");
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_power();
    test_samples();
    test_mid_burst_stb();
    test_wrap();
    test_bad_cmd();
    test_soft_reset();
    test_partial_write();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adxl362_spi_responder.md
Name: adxl362_spi_responder

Overview:
- Behavioural-synthesizable SPI responder that emulates the ADXL362 register interface, the far end of the accelerometer spi_master.
- Lets the X/Y flick chain (spi_master, shot_filter_xy, seg7_xy) run against scripted accelerations in simulation and on a loopback FPGA build, with no sensor attached.
- Oversamples SCLK/CSN/MOSI in the system clock domain, decodes read/write register commands, and serves sample registers from host-supplied X/Y/Z values.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/mosi (min 2)
- DEVID_AD, 8'hAD, value returned at address 0x00
- PARTID, 8'hF2, value returned at address 0x02

Ports:
- clk  in  1  system clock; must be >= 8x SCLK (100 MHz vs 1 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from master, mode 0
- cs_n  in  1  SPI chip select, active low
- mosi  in  1  master out
- miso  out  1  responder out
- x_sample  in  12  signed X acceleration, mg-scaled
- y_sample  in  12  signed Y acceleration
- z_sample  in  12  signed Z acceleration
- sample_stb  in  1  1-cycle strobe: latch new x/y/z_sample into staging
- measuring  out  1  POWER_CTL[1:0]==2'b10
- cmd_err  out  1  1-cycle pulse on an unsupported command byte

Behaviour:
- Reset: miso=0, measuring=0, cmd_err=0; POWER_CTL=0x00, FILTER_CTL=0x13; staging and snapshot = 0; FSM=IDLE.
- Inputs pass through SYNC_STAGES flops, then edge detect. Rise/fall acted on SYNC_STAGES+1 clk after the pin edge.
- cs_n fall: FSM->CMD, bit counter=0, snapshot<=staging, so a burst is coherent even if sample_stb fires mid-burst.
- cs_n rise in any state: FSM->IDLE, miso=0 on the next clk, partial byte discarded. A partial write is never committed.
- SPI mode 0, MSB first: mosi sampled on SCLK rise; miso updated on SCLK fall.
- FSM states: IDLE, CMD, ADDR, RD, WR, IGNORE.
  - CMD: after 8 rises, 0x0B->ADDR(read), 0x0A->ADDR(write), else cmd_err pulse and ->IGNORE.
  - ADDR: after 8 rises, load addr. Read ->RD, with tx_shift preloaded with reg[addr]. Write ->WR.
  - RD: bit7 of each byte is driven on the fall after the 8th preceding rise. After each 8 rises, addr<=addr+1 (8-bit wrap 0xFF->0x00) and tx_shift reloads.
  - WR: after each 8 rises, write the byte to reg[addr] if writable, then addr++ with wrap.
  - IGNORE: hold until cs_n rise; miso=0.
- Register map (read):
  - 00 DEVID_AD; 01 0x1D; 02 PARTID; 03 0x01
  - 08 X[11:4]; 09 Y[11:4]; 0A Z[11:4]
  - 0B STATUS
  - 0E X[7:0]; 0F {4{X[11]},X[11:8]}; 10/11 Y likewise; 12/13 Z likewise
  - 2C FILTER_CTL; 2D POWER_CTL
  - all others 0x00
- Sample registers return snapshot values when measuring=1, else 0x00.
- Writable: 2C, 2D. Address 1F written with 0x52 = soft reset: POWER_CTL and FILTER_CTL return to reset values at end of that byte. Other writes are ignored silently.
- A write then read in the same burst is impossible (single command per CS); a read of 2D in a later burst returns the value written.
- sample_stb during reset is ignored.

Optional Feature:
- ADXL_RESP_DRDY_EN
  - Defined: STATUS[0] DATA_READY sets on sample_stb (while measuring) and clears when a burst reads address 0x0E or 0x08 (cleared at cs_n rise). STATUS[6] AWAKE=measuring.
  - Undefined: STATUS reads constant {1'b0, measuring, 5'b0, 1'b1}.

Decomposition:
- Package adxl362_pkg: command constants (CMD_WR=8'h0A, CMD_RD=8'h0B), register address localparams, SOFT_RESET_KEY=8'h52, FSM state enum, POWER_CTL/FILTER_CTL reset values.
- Sub-module spi_edge_sync: synchronizer plus rise/fall detect for sclk/cs_n/mosi, reusable by the master bench.

Test Plan:
- Read ID burst 0x0B,0x00 plus 4 dummy bytes -> miso bytes AD,1D,F2,01.
- Write 0x0A,0x2D,0x02 then read 0x0B,0x2D -> 0x02; measuring=1.
- measuring=1, X=12'h9A5, Y=12'h123, stb; burst read from 0x0E, 4 bytes -> A5,F9,23,01. Same with measuring=0 -> 00,00,00,00.
- Mid-burst sample_stb after byte 1 of an X/Y burst -> all 4 bytes still from the old snapshot; next burst shows the new values.
- Read from 0xFF, 2 bytes -> 0x00 then DEVID_AD (wrap). Command 0x0D -> cmd_err pulse, miso=0 for the whole burst.
- Write 0x52 to 0x1F after POWER_CTL=0x02 -> POWER_CTL reads 0x00. Deassert cs_n after 4 bits of a data byte -> register unchanged. Assert rst_n low mid-read -> miso=0 immediately, FSM IDLE.
